// File: rtl/div_pkg.sv
// Shared state encoding, constants and sizing helper for the sequential
// restoring divider and its datapath step.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam int unsigned DIV_MAX_WIDTH = 16;

   // Quotient reported for a zero divisor; sliced down to the operand width.
   localparam logic [DIV_MAX_WIDTH-1:0] DIV_ALL_ONES = 16'hFFFF;

   // Ceiling log2 with a floor of one bit, used to size the step counter.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 32'd1;
      for (int unsigned i = 32'd1; i < 32'd31; i++) begin
         if ((32'd1 << i) < value) begin
            result = i + 32'd1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {R,Q} left, try to
// subtract the divisor, keep the difference and set the quotient bit if it fits.
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_trial;
   logic             w_negative;

   // One guard bit above the partial remainder makes the trial sign explicit.
   assign w_shift    = {i_rem, i_quo[WIDTH-1]};
   assign w_trial    = w_shift - {2'b00, i_divisor};
   assign w_negative = w_trial[WIDTH+1];

   assign o_rem = w_negative ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
   assign o_quo = {i_quo[WIDTH-2:0], ~w_negative};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake;
// produces one quotient bit per clock and flags division by zero.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = clog2(WIDTH);

   div_state_e       r_state;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_divisor;
   logic [CNT_W-1:0] r_count;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_by_zero;

   logic [WIDTH:0]   w_rem_next;
   logic [WIDTH-1:0] w_quo_next;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_divisor),
      .o_rem     (w_rem_next),
      .o_quo     (w_quo_next)
   );

   // Handshake FSM, iteration registers and registered results.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_rem         <= {(WIDTH+1){1'b0}};
         r_quo         <= {WIDTH{1'b0}};
         r_divisor     <= {WIDTH{1'b0}};
         r_count       <= {CNT_W{1'b0}};
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_quotient    <= {WIDTH{1'b0}};
         r_remainder   <= {WIDTH{1'b0}};
         r_div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
               if (start) begin
                  if (divisor == {WIDTH{1'b0}}) begin
                     r_quotient    <= DIV_ALL_ONES[WIDTH-1:0];
                     r_remainder   <= dividend;
                     r_div_by_zero <= 1'b1;
                     r_done        <= 1'b1;
                     r_state       <= DONE;
                  end else begin
                     r_rem     <= {(WIDTH+1){1'b0}};
                     r_quo     <= dividend;
                     r_divisor <= divisor;
                     r_count   <= CNT_W'(WIDTH - 32'd1);
                     r_busy    <= 1'b1;
                     r_state   <= RUN;
                  end
               end
            end
            RUN: begin
               r_rem   <= w_rem_next;
               r_quo   <= w_quo_next;
               r_count <= r_count - CNT_W'(1);
               // The final step's result goes straight to the outputs.
               if (r_count == {CNT_W{1'b0}}) begin
                  r_quotient    <= w_quo_next;
                  r_remainder   <= w_rem_next[WIDTH-1:0];
                  r_div_by_zero <= 1'b0;
                  r_busy        <= 1'b0;
                  r_done        <= 1'b1;
                  r_state       <= DONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus exhaustive
// and random operands against an arithmetic reference model.
module tb_seq_divider;

   localparam int unsigned W    = 4;
   localparam int unsigned MAXV = (32'd1 << W) - 32'd1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_checks = 0;
   int n_errors = 0;

   // Results the outputs are expected to hold between completions.
   int unsigned last_q = 0;
   int unsigned last_r = 0;
   int unsigned last_z = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model(input int unsigned a, input int unsigned b,
                                 output int unsigned q, output int unsigned r,
                                 output int unsigned z);
      if (b == 0) begin
         q = MAXV; r = a; z = 1;
      end else begin
         q = a / b; r = a % b; z = 0;
      end
   endfunction

   task automatic run_div(input int unsigned a, input int unsigned b);
      int unsigned eq, er, ez, lat;
      int          cyc;
      string       tag;
      logic [W-1:0] av, bv;
      tag = $sformatf("%0d/%0d", a, b);
      model(a, b, eq, er, ez);
      lat = (b == 0) ? 0 : W;
      av = a[W-1:0];
      bv = b[W-1:0];
      start = 1'b1; dividend = av; divisor = bv;
      tick();
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 3 * W) begin
         check_eq({tag, " busy"}, busy, 1);
         check_eq({tag, " hold_q"}, quotient, last_q);
         check_eq({tag, " hold_r"}, remainder, last_r);
         tick();
         cyc++;
      end
      check_eq({tag, " latency"}, cyc, lat);
      check_eq({tag, " q"}, quotient, eq);
      check_eq({tag, " r"}, remainder, er);
      check_eq({tag, " dbz"}, div_by_zero, ez);
      check_eq({tag, " busy_at_done"}, busy, 0);
      if (b != 0) begin
         check_eq({tag, " invariant"}, 32'(quotient) * b + 32'(remainder), a);
         check_eq({tag, " rem_lt_div"}, (32'(remainder) < b) ? 1 : 0, 1);
      end
      last_q = eq; last_r = er; last_z = ez;
      tick();
      check_eq({tag, " done_pulse"}, done, 0);
   endtask

   initial begin
      int cyc;
      int seen;

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      tick(); tick();
      rst = 1'b0;
      check_eq("reset busy", busy, 0);
      check_eq("reset done", done, 0);
      check_eq("reset q", quotient, 0);
      check_eq("reset r", remainder, 0);
      check_eq("reset dbz", div_by_zero, 0);

      // Reset during an iteration aborts without a done pulse
      start = 1'b1; dividend = 4'd15; divisor = 4'd3;
      tick();
      start = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("abort busy", busy, 0);
      check_eq("abort done", done, 0);
      check_eq("abort q", quotient, 0);
      check_eq("abort r", remainder, 0);
      check_eq("abort dbz", div_by_zero, 0);
      seen = 0;
      for (int i = 0; i < 2 * W; i++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      check_eq("abort no_done", seen, 0);
      last_q = 0; last_r = 0; last_z = 0;
      run_div(15, 3);

      // Directed corner values and divide-by-zero
      run_div(9, 6);
      run_div(15, 15);
      run_div(0, 10);
      run_div(3, 5);
      run_div(7, 0);
      check_eq("after dbz q", last_q, 15);
      run_div(8, 2);

      // Start while busy is ignored
      start = 1'b1; dividend = 4'd14; divisor = 4'd4;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; dividend = 4'd1; divisor = 4'd1;
      tick();
      start = 1'b0;
      cyc = 2;
      while (done !== 1'b1 && cyc < 3 * W) begin
         tick();
         cyc++;
      end
      check_eq("busy_start latency", cyc, W);
      check_eq("busy_start q", quotient, 3);
      check_eq("busy_start r", remainder, 2);
      tick();
      seen = 0;
      for (int i = 0; i < 3 * W; i++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      check_eq("busy_start extra_done", seen, 0);
      last_q = 3; last_r = 2; last_z = 0;

      // Back-to-back: new start accepted on the done cycle
      start = 1'b1; dividend = 4'd15; divisor = 4'd15;
      tick();
      cyc = 0;
      while (done !== 1'b1 && cyc < 3 * W) begin
         tick();
         cyc++;
      end
      check_eq("b2b first latency", cyc, W);
      check_eq("b2b first q", quotient, 1);
      check_eq("b2b first r", remainder, 0);
      dividend = 4'd9; divisor = 4'd6;
      tick();
      start = 1'b0;
      check_eq("b2b accept busy", busy, 1);
      cyc = 0;
      while (done !== 1'b1 && cyc < 3 * W) begin
         check_eq("b2b hold q", quotient, 1);
         check_eq("b2b hold r", remainder, 0);
         tick();
         cyc++;
      end
      check_eq("b2b second latency", cyc, W);
      check_eq("b2b second q", quotient, 1);
      check_eq("b2b second r", remainder, 3);
      last_q = 1; last_r = 3; last_z = 0;
      tick();

      // Product round trip: (a*b)/b recovers a
      for (int a = 1; a <= int'(MAXV); a++) begin
         for (int b = 1; b <= int'(MAXV); b++) begin
            if (a * b <= int'(MAXV)) begin
               run_div(a * b, b);
               check_eq($sformatf("roundtrip %0d*%0d", a, b), quotient, a);
            end
         end
      end

      // Exhaustive operand sweep
      for (int a = 0; a <= int'(MAXV); a++) begin
         for (int b = 0; b <= int'(MAXV); b++) begin
            run_div(a, b);
         end
      end

      // Random operands, zero divisor included
      for (int i = 0; i < 100; i++) begin
         run_div($urandom_range(MAXV, 0), $urandom_range(MAXV, 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
